// File: rtl/hls_run_ctrl_pkg.sv
// rtl/hls_run_ctrl_pkg.sv - shared FSM state type and saturating-increment helper for hls_run_ctrl
package hls_run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_START,
        S_EXE,
        S_DONE,
        S_ERR
    } state_t;

    localparam int SAT_MAX_W = 64;

    // Increment a w-bit value held in 64 bits; stays put once all w bits are set.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v, input int w);
        logic [SAT_MAX_W-1:0] max_v;
        max_v = (w >= SAT_MAX_W) ? {SAT_MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/hls_run_ctrl_if.sv
// rtl/hls_run_ctrl_if.sv - start/finish/return handshake between run controller and HLS accelerator
interface hls_run_ctrl_if #(
    parameter int RET_W = 32
);
    logic             acc_start;
    logic             acc_finish;
    logic [RET_W-1:0] acc_return_val;

    modport master (
        output acc_start,
        input  acc_finish,
        input  acc_return_val
    );

    modport slave (
        input  acc_start,
        output acc_finish,
        output acc_return_val
    );
endinterface

// File: rtl/hls_sat_counter.sv
// rtl/hls_sat_counter.sv - parametrised saturating counter with synchronous clear and enable
module hls_sat_counter
    import hls_run_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= WIDTH'(sat_inc(SAT_MAX_W'(count), WIDTH));
        end
    end

endmodule

// File: rtl/hls_run_ctrl.sv
// rtl/hls_run_ctrl.sv - multi-run launch controller for an HLS accelerator with cycle count and hang timeout
// Optional feature: RUN_CHECKSUM_EN adds an XOR checksum of all returned values since launch.
module hls_run_ctrl
    import hls_run_ctrl_pkg::*;
#(
    parameter int RET_W   = 32,
    parameter int CYC_W   = 32,
    parameter int RUNS_W  = 8,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [RUNS_W-1:0] num_runs,
    hls_run_ctrl_if.master    acc,
    output logic [RET_W-1:0]  return_val_reg,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [RUNS_W-1:0] run_idx,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
`ifdef RUN_CHECKSUM_EN
    ,
    output logic [RET_W-1:0]  checksum
`endif
);

    state_t            state;
    logic              go_q;
    logic [RUNS_W-1:0] runs_q;
    logic [CYC_W-1:0]  run_cyc;

    logic go_rise;
    logic idle;
    logic launch;
    logic in_start;
    logic in_exe;
    logic finish_ok;
    logic last_run;
    logic timed_out;

    assign go_rise   = go & ~go_q;
    assign idle      = (state == S_WAIT) || (state == S_DONE) || (state == S_ERR);
    assign launch    = idle & go_rise;
    assign in_start  = (state == S_START);
    assign in_exe    = (state == S_EXE);
    assign finish_ok = in_exe & acc.acc_finish;
    assign last_run  = (run_idx == runs_q - RUNS_W'(1));
    // A finish arriving on the limit cycle beats the timeout.
    assign timed_out = in_exe & ~acc.acc_finish & (TIMEOUT != 0)
                     & (run_cyc == CYC_W'(TIMEOUT - 1));

    assign acc.acc_start = in_start;
    assign busy          = in_start | in_exe;
    assign done          = (state == S_DONE);
    assign timeout_err   = (state == S_ERR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            go_q <= 1'b0;
        end else begin
            go_q <= go;
        end
    end

    hls_sat_counter #(
        .WIDTH (CYC_W)
    ) u_cycle_count (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (launch),
        .enable  (busy),
        .count   (cycle_count)
    );

    hls_sat_counter #(
        .WIDTH (CYC_W)
    ) u_run_cyc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (in_start),
        .enable  (in_exe),
        .count   (run_cyc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_WAIT;
            runs_q         <= '0;
            run_idx        <= '0;
            return_val_reg <= '0;
`ifdef RUN_CHECKSUM_EN
            checksum       <= '0;
`endif
        end else begin
            case (state)
                S_WAIT, S_DONE, S_ERR: begin
                    if (go_rise) begin
                        state          <= S_START;
                        runs_q         <= (num_runs == '0) ? RUNS_W'(1) : num_runs;
                        run_idx        <= '0;
                        return_val_reg <= '0;
`ifdef RUN_CHECKSUM_EN
                        checksum       <= '0;
`endif
                    end
                end
                S_START: begin
                    state <= S_EXE;
                end
                S_EXE: begin
                    if (finish_ok) begin
                        return_val_reg <= acc.acc_return_val;
`ifdef RUN_CHECKSUM_EN
                        checksum       <= checksum ^ acc.acc_return_val;
`endif
                        if (last_run) begin
                            state <= S_DONE;
                        end else begin
                            run_idx <= run_idx + RUNS_W'(1);
                            state   <= S_START;
                        end
                    end else if (timed_out) begin
                        state <= S_ERR;
                    end
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule
